// File: rtl/execute_unit_mdu.sv
// Execute stage with valid/ready handshakes, branch resolution and an optional
// RV32M/RV64M multiply/divide unit (multi-cycle MUL, iterative restoring DIV).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       drop the in-flight op and any presented result
//   in_valid / in_ready         decode-side handshake
//   in_class, in_op, in_alu_src op class, {mdu, alt, funct3}, b-operand select
//   in_rs1, in_rs2, in_imm, in_pc, in_rd, in_reg_write, in_mem_read, in_mem_write
//   out_valid / out_ready       memory-side handshake
//   out_result, out_rs2, out_rd, out_reg_write, out_mem_read, out_mem_write
//   redirect, redirect_pc       taken branch / jump, valid only with out_valid
module execute_unit_mdu #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned ENABLE_MDU = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_class,
  input  logic [4:0]         in_op,
  input  logic               in_alu_src,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_rs2,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam int unsigned SHW      = $clog2(XLEN);
  localparam int unsigned CNTW     = $clog2(XLEN + 2);
  localparam int unsigned MCW      = (MUL_STAGES > 2) ? $clog2(MUL_STAGES - 1) : 1;
  localparam int unsigned MUL_INIT = (MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_BRANCH = 3'd1;
  localparam logic [2:0] CLS_LUI    = 3'd2;
  localparam logic [2:0] CLS_AUIPC  = 3'd3;
  localparam logic [2:0] CLS_JAL    = 3'd4;
  localparam logic [2:0] CLS_JALR   = 3'd5;
  localparam logic [2:0] CLS_LDST   = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} stateT;

  stateT               state;
  logic [XLEN-1:0]     mulHold;
  logic [MCW-1:0]      mulCnt;
  logic [XLEN-1:0]     divQuo;
  logic [XLEN-1:0]     divRem;
  logic [XLEN-1:0]     divDsr;
  logic [XLEN-1:0]     divDividend;
  logic                divNegQ;
  logic                divNegR;
  logic                divIsRem;
  logic [CNTW-1:0]     divStep;

  logic                isAlu, mduOp, isMdu, accept;
  logic [XLEN-1:0]     opA, opB, aluRes, singleRes;
  logic [XLEN-1:0]     pcPlusImm, rs1PlusImm, redirPcNext;
  logic [2:0]          aluF3;
  logic                aluAlt, takenBr, redirNext;
  logic [SHW-1:0]      shamt;
  logic                mulASigned, mulBSigned;
  logic [2*XLEN-1:0]   mulA, mulB, mulProd;
  logic [XLEN-1:0]     mulResNow;
  logic                divSignedIn, negA, negB;
  logic [XLEN-1:0]     absA, absB;
  logic [XLEN:0]       remShift, remDiff;
  logic [XLEN-1:0]     quoFinal, remFinal;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Operand selection, ALU, branch compare and jump targets for the offered op
  always_comb begin
    isAlu = (in_class == CLS_ALU);
    mduOp = isAlu && in_op[4];
    isMdu = mduOp && (ENABLE_MDU != 0);

    opA = in_rs1;
    if (in_class == CLS_AUIPC || in_class == CLS_JAL || in_class == CLS_JALR) opA = in_pc;
    if (in_class == CLS_LUI) opA = '0;
    opB = (in_alu_src || in_class == CLS_LUI || in_class == CLS_AUIPC || in_class == CLS_LDST)
          ? in_imm : in_rs2;

    // Non-ALU classes and disabled-MDU ops all reduce to a plain add
    aluF3  = (isAlu && !mduOp) ? in_op[2:0] : 3'b000;
    aluAlt = isAlu && !mduOp && in_op[3];
    shamt  = opB[SHW-1:0];

    aluRes = '0;
    case (aluF3)
      3'b000: aluRes = aluAlt ? (opA - opB) : (opA + opB);
      3'b001: aluRes = opA << shamt;
      3'b010: aluRes = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      3'b011: aluRes = {{(XLEN-1){1'b0}}, (opA < opB)};
      3'b100: aluRes = opA ^ opB;
      3'b101: aluRes = aluAlt ? $unsigned($signed(opA) >>> shamt) : (opA >> shamt);
      3'b110: aluRes = opA | opB;
      default: aluRes = opA & opB;
    endcase

    takenBr = 1'b0;
    case (in_op[2:0])
      3'b000: takenBr = (in_rs1 == in_rs2);
      3'b001: takenBr = (in_rs1 != in_rs2);
      3'b100: takenBr = ($signed(in_rs1) <  $signed(in_rs2));
      3'b101: takenBr = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110: takenBr = (in_rs1 <  in_rs2);
      3'b111: takenBr = (in_rs1 >= in_rs2);
      default: takenBr = 1'b0;
    endcase

    pcPlusImm   = in_pc + in_imm;
    rs1PlusImm  = in_rs1 + in_imm;
    redirNext   = ((in_class == CLS_BRANCH) && takenBr) ||
                  (in_class == CLS_JAL) || (in_class == CLS_JALR);
    redirPcNext = (in_class == CLS_JALR) ? (rs1PlusImm & ~XLEN'(1)) : pcPlusImm;
    singleRes   = (in_class == CLS_JAL || in_class == CLS_JALR) ? (in_pc + XLEN'(4)) : aluRes;
  end

  // Multiplier: sign-extend per MULH/MULHSU/MULHU, keep low or high half
  always_comb begin
    mulASigned = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
    mulBSigned = (in_op[1:0] == 2'b01);
    mulA       = mulASigned ? {{XLEN{opA[XLEN-1]}}, opA} : {{XLEN{1'b0}}, opA};
    mulB       = mulBSigned ? {{XLEN{opB[XLEN-1]}}, opB} : {{XLEN{1'b0}}, opB};
    mulProd    = mulA * mulB;
    mulResNow  = (in_op[1:0] == 2'b00) ? mulProd[XLEN-1:0] : mulProd[2*XLEN-1:XLEN];
  end

  // Divider: setup magnitudes at accept, one restoring step, final sign fix
  always_comb begin
    divSignedIn = !in_op[0];
    negA        = divSignedIn && opA[XLEN-1];
    negB        = divSignedIn && opB[XLEN-1];
    absA        = negA ? (-opA) : opA;
    absB        = negB ? (-opB) : opB;

    remShift = {divRem, divQuo[XLEN-1]};
    remDiff  = remShift - {1'b0, divDsr};

    // Divide-by-zero bypasses the sign fix; min/-1 falls out of the magnitudes
    if (divDsr == '0) begin
      quoFinal = '1;
      remFinal = divDividend;
    end else begin
      quoFinal = divNegQ ? (-divQuo) : divQuo;
      remFinal = divNegR ? (-divRem) : divRem;
    end
  end

  // Control FSM with registered result, controls and redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      mulHold       <= '0;
      mulCnt        <= '0;
      divQuo        <= '0;
      divRem        <= '0;
      divDsr        <= '0;
      divDividend   <= '0;
      divNegQ       <= 1'b0;
      divNegR       <= 1'b0;
      divIsRem      <= 1'b0;
      divStep       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      redirect  <= 1'b0;
      mulCnt    <= '0;
      divStep   <= '0;
      divQuo    <= '0;
      divRem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            redirect  <= 1'b0;
          end
          if (accept) begin
            out_rs2       <= in_rs2;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write && (in_class != CLS_BRANCH);
            out_mem_read  <= in_mem_read;
            out_mem_write <= in_mem_write;
            if (isMdu) begin
              redirect <= 1'b0;
              if (in_op[2]) begin
                state       <= DIV;
                out_valid   <= 1'b0;
                divQuo      <= absA;
                divRem      <= '0;
                divDsr      <= absB;
                divDividend <= opA;
                divNegQ     <= negA ^ negB;
                divNegR     <= negA;
                divIsRem    <= in_op[1];
                divStep     <= CNTW'(1);
              end else begin
                state   <= MUL;
                mulHold <= mulResNow;
                mulCnt  <= MCW'(MUL_INIT);
                // A single-stage multiply is presented straight from accept
                if (MUL_STAGES <= 1) begin
                  out_valid  <= 1'b1;
                  out_result <= mulResNow;
                end else begin
                  out_valid <= 1'b0;
                end
              end
            end else begin
              out_valid   <= 1'b1;
              out_result  <= singleRes;
              redirect    <= redirNext;
              redirect_pc <= redirPcNext;
            end
          end
        end
        MUL: begin
          if (!out_valid) begin
            if (mulCnt == '0) begin
              out_valid  <= 1'b1;
              out_result <= mulHold;
            end else begin
              mulCnt <= mulCnt - MCW'(1);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        DIV: begin
          if (!out_valid) begin
            if (divStep <= CNTW'(XLEN)) begin
              if (!remDiff[XLEN]) begin
                divRem <= remDiff[XLEN-1:0];
                divQuo <= {divQuo[XLEN-2:0], 1'b1};
              end else begin
                divRem <= remShift[XLEN-1:0];
                divQuo <= {divQuo[XLEN-2:0], 1'b0};
              end
              divStep <= divStep + CNTW'(1);
            end else begin
              out_valid  <= 1'b1;
              out_result <= divIsRem ? remFinal : quoFinal;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit_mdu.sv
// Bench for execute_unit_mdu: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_execute_unit_mdu;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int          MUL_LAT = 2;
  localparam int          DIV_LAT = XLEN + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_class;
  logic [4:0]         in_op;
  logic               in_alu_src;
  logic [XLEN-1:0]    in_rs1, in_rs2, in_imm, in_pc;
  logic [RADDR_W-1:0] in_rd;
  logic               in_reg_write, in_mem_read, in_mem_write;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result, out_rs2;
  logic [RADDR_W-1:0] out_rd;
  logic               out_reg_write, out_mem_read, out_mem_write;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;

  int nCmp  = 0;
  int nFail = 0;

  execute_unit_mdu #(.XLEN(XLEN), .RADDR_W(RADDR_W), .MUL_STAGES(MUL_LAT), .ENABLE_MDU(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_op(in_op), .in_alu_src(in_alu_src),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from the instruction semantics, using plain integer arithmetic
  function automatic void refModel(input logic [2:0] cls, input logic [4:0] op, input logic src,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   output logic [31:0] res, output logic redir,
                                   output logic [31:0] rpc, output int lat);
    logic [31:0] a, b;
    int sa, sb, tmp;
    longint pa, pb;
    logic [63:0] pu;
    logic ovf;
    a = (cls == 3'd3 || cls == 3'd4 || cls == 3'd5) ? pc : ((cls == 3'd2) ? 32'd0 : rs1);
    b = (src || cls == 3'd2 || cls == 3'd3 || cls == 3'd6) ? imm : rs2;
    sa = a; sb = b;
    res = a + b; redir = 1'b0; rpc = pc + imm; lat = 1;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    if (cls == 3'd0 && op[4]) begin
      lat = op[2] ? DIV_LAT : MUL_LAT;
      case (op[2:0])
        3'd0: res = a * b;
        3'd1: begin pa = sa; pb = sb; pu = pa * pb; res = pu[63:32]; end
        3'd2: begin pa = sa; pb = {32'd0, b}; pu = pa * pb; res = pu[63:32]; end
        3'd3: begin pu = {32'd0, a} * {32'd0, b}; res = pu[63:32]; end
        3'd4: begin
          if (b == 0) res = 32'hFFFFFFFF;
          else if (ovf) res = a;
          else begin tmp = sa / sb; res = tmp; end
        end
        3'd5: res = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) res = a;
          else if (ovf) res = 32'd0;
          else begin tmp = sa % sb; res = tmp; end
        end
        default: res = (b == 0) ? a : a % b;
      endcase
    end else if (cls == 3'd0) begin
      case (op[2:0])
        3'd0: res = op[3] ? a - b : a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: begin if (op[3]) begin tmp = sa >>> b[4:0]; res = tmp; end else res = a >> b[4:0]; end
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (cls == 3'd1) begin
      case (op[2:0])
        3'd0: redir = (rs1 == rs2);
        3'd1: redir = (rs1 != rs2);
        3'd4: redir = ($signed(rs1) <  $signed(rs2));
        3'd5: redir = ($signed(rs1) >= $signed(rs2));
        3'd6: redir = (rs1 <  rs2);
        3'd7: redir = (rs1 >= rs2);
        default: redir = 1'b0;
      endcase
    end else if (cls == 3'd4) begin
      res = pc + 32'd4; redir = 1'b1;
    end else if (cls == 3'd5) begin
      res = pc + 32'd4; redir = 1'b1; rpc = (rs1 + imm) & 32'hFFFFFFFE;
    end
  endfunction

  // Offer one op, await its result, check it, optionally stall, then transfer
  task automatic runOp(input logic [2:0] cls, input logic [4:0] op, input logic src,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input int stall, input string tag);
    logic [31:0] eRes, eRpc, held;
    logic eRedir, stable;
    int eLat, lat, guard, leak;
    refModel(cls, op, src, rs1, rs2, imm, pc, eRes, eRedir, eRpc, eLat);
    in_class = cls; in_op = op; in_alu_src = src;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
    in_rd = rd; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; leak = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) leak++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(eLat));
    chk({tag, "_busy_in_ready"}, 64'(leak), 64'd0);
    if (cls != 3'd1) chk({tag, "_result"}, 64'(out_result), 64'(eRes));
    chk({tag, "_redirect"}, 64'(redirect), 64'(eRedir));
    if (eRedir) chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'(eRpc));
    chk({tag, "_rd"}, 64'(out_rd), 64'(rd));
    chk({tag, "_rs2"}, 64'(out_rs2), 64'(rs2));
    chk({tag, "_ctrl"}, 64'({out_reg_write, out_mem_read, out_mem_write}),
        64'({rw && (cls != 3'd1), mr, mw}));
    if (stall > 0) begin
      held = out_result; stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (!out_valid || out_result !== held || in_ready) stable = 1'b0;
      end
      chk({tag, "_stall_stable"}, 64'(stable), 64'd1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 16));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_op = '0; in_alu_src = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
    in_rd = '0; in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_ctrl", 64'({out_rd, out_reg_write, out_mem_read, out_mem_write}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp(3'd0, 5'b00000, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 0, "add_wrap");
    runOp(3'd1, 5'b00110, 1'b0, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 5'd1, 1'b1, 1'b0, 1'b0, 0, "bltu");
    runOp(3'd1, 5'b00100, 1'b0, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 5'd1, 1'b1, 1'b0, 1'b0, 0, "blt");
    runOp(3'd0, 5'b10100, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 0, "div_ovf");
    runOp(3'd0, 5'b10110, 1'b0, 32'd7, 32'd0, 32'd0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 0, "rem_zero");
    runOp(3'd0, 5'b10011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 5, "mulhu_stall");
    runOp(3'd5, 5'b00000, 1'b1, 32'h1003, 32'd0, 32'd0, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 0, "jalr");
    runOp(3'd6, 5'b00010, 1'b1, 32'h2000, 32'hCAFE, 32'hFFFFFFFC, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 2, "store");

    // flush alongside an offered op: the op must not be taken
    in_class = 3'd0; in_op = 5'b00000; in_alu_src = 1'b0;
    in_rs1 = 32'd5; in_rs2 = 32'd6; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_idle_valid2", 64'(out_valid), 64'd0);

    // flush in the middle of a divide
    in_op = 5'b10101; in_rs1 = 32'd100; in_rs2 = 32'd7; in_rd = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_div_busy", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_div_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush_div_no_valid", 64'(seen), 64'd0);

    // reset in the middle of a divide
    in_op = 5'b10100; in_rs1 = 32'd99; in_rs2 = 32'd3; in_rd = 5'd17;
    in_reg_write = 1'b1; in_mem_read = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_div_valid", 64'(out_valid), 64'd0);
    chk("rst_div_ready", 64'(in_ready), 64'd1);
    chk("rst_div_outs", 64'({out_rd, out_reg_write, out_mem_read, out_mem_write, redirect}), 64'd0);
    chk("rst_div_data", 64'({out_result, out_rs2}), 64'd0);
    runOp(3'd0, 5'b00000, 1'b0, 32'd40, 32'd2, 32'd0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 0, "add_after_rst");

    // randomized ops across all classes
    for (int n = 0; n < 120; n++) begin
      logic [2:0] rc;
      rc = 3'($urandom_range(0, 6));
      runOp(rc, 5'($urandom), 1'($urandom), randVal(), randVal(), randVal(),
            32'($urandom) & 32'hFFFFFFFC, 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
